uart_rfifo_ctrl: RTL and testbench
==================================

# uart_rfifo_ctrl

Sequencing and status controller for the UART receiver FIFO. It turns register-level reads of RBR, LSR and FCR into single-cycle FIFO pop, reset and status-clear strobes. It also derives the receiver interrupt sources (data-available trigger, character timeout, line status) from the FIFO count, error and overrun flags. It sits between the register decode and the receive FIFO instance.

## Interface
- fifo_depth, 16, FIFO capacity in words
- fifo_counter_w, 5, width of the FIFO count
- toc_chars, 4, character times of inactivity before a timeout interrupt is raised
- clk  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- rbr_rd  in  1  level; high while a Wishbone read of RBR is in progress (may last several cycles)
- lsr_rd  in  1  one-cycle strobe on an LSR read
- fcr_we  in  1  one-cycle FCR write strobe
- fcr_di  in  8  FCR write data; bit 1 = rx clear, bits 7:6 = trigger select
- rx_push  in  1  receiver push into the FIFO, observed for timeout restart
- char_tick  in  1  one-cycle pulse per character time, from baud logic
- ier_rda  in  1  data-available / timeout interrupt enable
- ier_rls  in  1  line-status interrupt enable
- rf_count  in  fifo_counter_w  FIFO occupancy
- rf_error_bit  in  1  FIFO error summary
- rf_overrun  in  1  FIFO overrun flag
- rf_pop  out  1  FIFO pop strobe
- rf_fifo_reset  out  1  FIFO clear strobe
- rf_reset_status  out  1  FIFO overrun clear strobe
- lsr_dr  out  1  data ready (rf_count != 0)
- rda_int  out  1  data-available interrupt
- ti_int  out  1  character-timeout interrupt
- rls_int  out  1  line-status interrupt

## Operation
- Pop FSM states:
  - IDLE: if rbr_rd and rf_count != 0, go to POP. If rbr_rd and rf_count == 0, go to HOLD without popping.
  - POP: rf_pop = 1 for exactly one cycle, then go to HOLD.
  - HOLD: wait for rbr_rd = 0, then go to IDLE.
- Result: exactly one pop per RBR read, however long the read strobe is held.
- FCR write with fcr_di[1] = 1:
  - rf_fifo_reset is pulsed in the following cycle.
  - The FSM is forced to IDLE, or to HOLD if rbr_rd is high.
  - The timeout counter is cleared.
- FCR trigger latch: trig[1:0] is latched from fcr_di[7:6] on every fcr_we. Threshold map: 00→1, 01→4, 10→8, 11→14. Reset value of trig is 11.
- rda_int = ier_rda & (rf_count >= threshold). Purely comparative, registered.
- Timeout counter (3-bit):
  - Cleared on rx_push, rf_pop, FIFO clear, or rf_count == 0.
  - Otherwise increments on char_tick, saturating at toc_chars.
  - ti_int = ier_rda & (counter == toc_chars) & (rf_count != 0).
- LSR read: lsr_rd pulses rf_reset_status in the following cycle, which clears the overrun flag.
- rls_int:
  - Set when ier_rls & (rf_overrun | rf_error_bit).
  - Cleared by lsr_rd, then re-evaluated from the next cycle.
- Priority, highest first: reset, FIFO clear, pop. A clear requested in the same cycle as an entry to POP suppresses rf_pop.

## Timing
- Reset values: all strobes 0, lsr_dr 0, all interrupts 0, FSM IDLE, counter 0, trig 11.
- All outputs are registered.
- rf_pop asserts 1 cycle after rbr_rd rises.
- rf_fifo_reset asserts 1 cycle after fcr_we; rf_reset_status asserts 1 cycle after lsr_rd. Each is exactly 1 cycle wide.
- rda_int, lsr_dr and ti_int lag their inputs by 1 cycle.
- rls_int is low in the cycle after lsr_rd.
- Reset mid-operation (FSM in POP or HOLD) returns to IDLE immediately; no pop is issued.
- Counter saturation: additional char_tick pulses do not wrap.
- rx_push coinciding with the saturation tick: the clear wins.

## Structure
- Shared package / uart_defines:
  - FCR bit positions (RX_CLR = 1, TRIG = 7:6)
  - trigger encodings and threshold constants (1, 4, 8, 14)
  - FSM state encoding (IDLE, POP, HOLD, 2-bit)
  - UART_FIFO_DEPTH and UART_FIFO_COUNTER_W
- Natural sub-module: uart_rx_timeout (saturating char-time counter plus ti_int qualification).
- Everything else is flat.

## Test plan
- Reset with rf_count = 5, then hold rbr_rd high for 6 cycles -> a single rf_pop pulse 1 cycle after the rise, none while held. A second assertion produces a second pop.
- rf_count = 0, rbr_rd pulsed -> no rf_pop; FSM returns to IDLE after rbr_rd falls.
- FCR write 0xC2 in the same cycle rbr_rd rises with count 3:
  - rf_fifo_reset pulses and no rf_pop is issued
  - trig = 11, so rda_int asserts only once rf_count reaches 14.
- trig = 01, rf_count stepped 3→4→3 -> rda_int goes 0→1→0, each change 1 cycle after the count change.
- rf_count = 2, no push or pop, 4 char_tick pulses -> ti_int rises after the 4th tick. A pop clears it; rx_push on the 4th tick prevents it.
- Overrun sequence:
  - rf_overrun = 1 with ier_rls = 1 -> rls_int = 1.
  - lsr_rd -> rf_reset_status pulse and rls_int = 0.
  - rf_error_bit held at 1 -> rls_int reasserts on the next cycle.

Source files
------------

// File: rtl/uart_rfifo_ctrl_pkg.sv
// Shared constants for the UART receive-FIFO controller: FCR field positions,
// trigger-level encodings and thresholds, pop FSM state codes, FIFO geometry.
package uart_rfifo_ctrl_pkg;

   localparam int UART_FIFO_DEPTH     = 16;
   localparam int UART_FIFO_COUNTER_W = 5;
   localparam int UART_TOC_CHARS      = 4;

   // FCR field positions
   localparam int FCR_RX_CLR  = 1;
   localparam int FCR_TRIG_HI = 7;
   localparam int FCR_TRIG_LO = 6;

   // Trigger-level encodings (FCR[7:6]) and the occupancy each one stands for
   localparam logic [1:0] TRIG_1  = 2'b00;
   localparam logic [1:0] TRIG_4  = 2'b01;
   localparam logic [1:0] TRIG_8  = 2'b10;
   localparam logic [1:0] TRIG_14 = 2'b11;

   localparam logic [7:0] TH_1  = 8'd1;
   localparam logic [7:0] TH_4  = 8'd4;
   localparam logic [7:0] TH_8  = 8'd8;
   localparam logic [7:0] TH_14 = 8'd14;

   // Pop FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_POP  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Map a trigger encoding to its occupancy threshold
   function automatic logic [7:0] trig_threshold(input logic [1:0] trig);
      logic [7:0] th;
      case (trig)
         TRIG_1:  th = TH_1;
         TRIG_4:  th = TH_4;
         TRIG_8:  th = TH_8;
         default: th = TH_14;
      endcase
      return th;
   endfunction

endpackage

// File: rtl/uart_rfifo_ctrl_rx_timeout.sv
// Character-timeout detector: a saturating count of character times with no
// FIFO activity, qualified into the ti_int interrupt.
module uart_rx_timeout
   import uart_rfifo_ctrl_pkg::*;
#(
   parameter int toc_chars = UART_TOC_CHARS
) (
   input  logic clk,
   input  logic wb_rst_i,
   input  logic clr,
   input  logic char_tick,
   input  logic ier_rda,
   input  logic count_nz,
   output logic ti_int
);

   localparam logic [2:0] TOC = 3'(toc_chars);

   logic [2:0] cnt_q, cnt_d;
   logic       ti_int_q, ti_int_d;

   // Next count: any activity clears (and wins over a tick), else count ticks up to TOC
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 3'd0;
      end else if (char_tick && (cnt_q != TOC)) begin
         cnt_d = cnt_q + 3'd1;
      end
      ti_int_d = ier_rda & (cnt_d == TOC) & count_nz;
   end

   // Counter and interrupt registers
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_q    <= 3'd0;
         ti_int_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ti_int_q <= ti_int_d;
      end
   end

   assign ti_int = ti_int_q;

endmodule

// File: rtl/uart_rfifo_ctrl.sv
// UART receive-FIFO controller: turns RBR/LSR/FCR register accesses into
// single-cycle FIFO strobes and derives the receiver interrupt sources.
module uart_rfifo_ctrl
   import uart_rfifo_ctrl_pkg::*;
#(
   parameter int fifo_depth     = UART_FIFO_DEPTH,
   parameter int fifo_counter_w = UART_FIFO_COUNTER_W,
   parameter int toc_chars      = UART_TOC_CHARS
) (
   input  logic                      clk,
   input  logic                      wb_rst_i,
   input  logic                      rbr_rd,
   input  logic                      lsr_rd,
   input  logic                      fcr_we,
   input  logic [7:0]                fcr_di,
   input  logic                      rx_push,
   input  logic                      char_tick,
   input  logic                      ier_rda,
   input  logic                      ier_rls,
   input  logic [fifo_counter_w-1:0] rf_count,
   input  logic                      rf_error_bit,
   input  logic                      rf_overrun,
   output logic                      rf_pop,
   output logic                      rf_fifo_reset,
   output logic                      rf_reset_status,
   output logic                      lsr_dr,
   output logic                      rda_int,
   output logic                      ti_int,
   output logic                      rls_int
);

   // A trigger level above the FIFO capacity could never fire; cap it.
   localparam logic [fifo_counter_w-1:0] DEPTH_CAP = fifo_counter_w'(fifo_depth);

   logic [1:0] state_q, state_d;
   logic [1:0] trig_q, trig_d;
   logic       rf_pop_q, rf_pop_d;
   logic       rf_fifo_reset_q, rf_fifo_reset_d;
   logic       rf_reset_status_q, rf_reset_status_d;
   logic       lsr_dr_q, lsr_dr_d;
   logic       rda_int_q, rda_int_d;
   logic       rls_int_q, rls_int_d;

   logic                      rx_clr_req;
   logic                      count_nz;
   logic [fifo_counter_w-1:0] thresh_raw, thresh;
   logic                      unused_fcr;

   assign rx_clr_req = fcr_we & fcr_di[FCR_RX_CLR];
   assign count_nz   = (rf_count != '0);
   assign unused_fcr = ^{fcr_di[5:2], fcr_di[0]};

   // Pop FSM: one pop per RBR read regardless of strobe length; a FIFO clear overrides
   always_comb begin
      state_d  = state_q;
      rf_pop_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rbr_rd) begin
               if (count_nz) begin
                  state_d  = ST_POP;
                  rf_pop_d = 1'b1;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_POP:  state_d = ST_HOLD;
         ST_HOLD: if (!rbr_rd) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (rx_clr_req) begin
         state_d  = rbr_rd ? ST_HOLD : ST_IDLE;
         rf_pop_d = 1'b0;
      end
   end

   // Strobes, trigger latch and status/interrupt next values
   always_comb begin
      trig_d            = fcr_we ? fcr_di[FCR_TRIG_HI:FCR_TRIG_LO] : trig_q;
      thresh_raw        = fifo_counter_w'(trig_threshold(trig_q));
      thresh            = (thresh_raw > DEPTH_CAP) ? DEPTH_CAP : thresh_raw;
      rf_fifo_reset_d   = rx_clr_req;
      rf_reset_status_d = lsr_rd;
      lsr_dr_d          = count_nz;
      rda_int_d         = ier_rda & (rf_count >= thresh);
      rls_int_d         = ~lsr_rd & ier_rls & (rf_overrun | rf_error_bit);
   end

   // State and output registers
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q           <= ST_IDLE;
         trig_q            <= TRIG_14;
         rf_pop_q          <= 1'b0;
         rf_fifo_reset_q   <= 1'b0;
         rf_reset_status_q <= 1'b0;
         lsr_dr_q          <= 1'b0;
         rda_int_q         <= 1'b0;
         rls_int_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         trig_q            <= trig_d;
         rf_pop_q          <= rf_pop_d;
         rf_fifo_reset_q   <= rf_fifo_reset_d;
         rf_reset_status_q <= rf_reset_status_d;
         lsr_dr_q          <= lsr_dr_d;
         rda_int_q         <= rda_int_d;
         rls_int_q         <= rls_int_d;
      end
   end

   uart_rx_timeout #(
      .toc_chars (toc_chars)
   ) u_rx_timeout (
      .clk       (clk),
      .wb_rst_i  (wb_rst_i),
      .clr       (rx_push | rf_pop_q | rx_clr_req | ~count_nz),
      .char_tick (char_tick),
      .ier_rda   (ier_rda),
      .count_nz  (count_nz),
      .ti_int    (ti_int)
   );

   assign rf_pop          = rf_pop_q;
   assign rf_fifo_reset   = rf_fifo_reset_q;
   assign rf_reset_status = rf_reset_status_q;
   assign lsr_dr          = lsr_dr_q;
   assign rda_int         = rda_int_q;
   assign rls_int         = rls_int_q;

endmodule

// File: tb/tb_uart_rfifo_ctrl.sv
// Self-checking bench for uart_rfifo_ctrl: per-scenario tasks push expected
// output vectors into a scoreboard as stimulus is applied and compare after the edge.
module tb_uart_rfifo_ctrl;

   // Output vector bit weights: {pop, fifo_reset, reset_status, lsr_dr, rda, ti, rls}
   localparam logic [6:0] P  = 7'b1000000;
   localparam logic [6:0] FR = 7'b0100000;
   localparam logic [6:0] RS = 7'b0010000;
   localparam logic [6:0] DR = 7'b0001000;
   localparam logic [6:0] RD = 7'b0000100;
   localparam logic [6:0] TI = 7'b0000010;
   localparam logic [6:0] RL = 7'b0000001;

   typedef struct {
      logic       rbr, lsr, fwe;
      logic [7:0] fdi;
      logic       push, tick;
      logic [4:0] cnt;
      logic       ovr, err;
      logic [6:0] exp;
   } stim_t;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       rbr_rd = 1'b0, lsr_rd = 1'b0, fcr_we = 1'b0;
   logic [7:0] fcr_di = 8'h00;
   logic       rx_push = 1'b0, char_tick = 1'b0;
   logic       ier_rda = 1'b0, ier_rls = 1'b0;
   logic [4:0] rf_count = 5'd0;
   logic       rf_error_bit = 1'b0, rf_overrun = 1'b0;
   logic       rf_pop, rf_fifo_reset, rf_reset_status, lsr_dr, rda_int, ti_int, rls_int;
   logic [6:0] outs;

   int         vectors = 0;
   int         miscompares = 0;
   logic [6:0] sb[$];

   assign outs = {rf_pop, rf_fifo_reset, rf_reset_status, lsr_dr, rda_int, ti_int, rls_int};

   always #5 clk = ~clk;

   uart_rfifo_ctrl dut (
      .clk             (clk),
      .wb_rst_i        (wb_rst_i),
      .rbr_rd          (rbr_rd),
      .lsr_rd          (lsr_rd),
      .fcr_we          (fcr_we),
      .fcr_di          (fcr_di),
      .rx_push         (rx_push),
      .char_tick       (char_tick),
      .ier_rda         (ier_rda),
      .ier_rls         (ier_rls),
      .rf_count        (rf_count),
      .rf_error_bit    (rf_error_bit),
      .rf_overrun      (rf_overrun),
      .rf_pop          (rf_pop),
      .rf_fifo_reset   (rf_fifo_reset),
      .rf_reset_status (rf_reset_status),
      .lsr_dr          (lsr_dr),
      .rda_int         (rda_int),
      .ti_int          (ti_int),
      .rls_int         (rls_int)
   );

   function automatic stim_t mk(input logic rbr, input logic lsr, input logic fwe,
                                input logic [7:0] fdi, input logic push, input logic tick,
                                input logic [4:0] cnt, input logic ovr, input logic err,
                                input logic [6:0] exp);
      stim_t s;
      s.rbr = rbr; s.lsr = lsr; s.fwe = fwe; s.fdi = fdi; s.push = push;
      s.tick = tick; s.cnt = cnt; s.ovr = ovr; s.err = err; s.exp = exp;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rbr_rd = s.rbr; lsr_rd = s.lsr; fcr_we = s.fwe; fcr_di = s.fdi;
      rx_push = s.push; char_tick = s.tick; rf_count = s.cnt;
      rf_overrun = s.ovr; rf_error_bit = s.err;
   endtask

   task automatic test_reset();
      rf_count = 5'd5; ier_rda = 1'b1; ier_rls = 1'b1; rf_overrun = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_state outs=%b expected=%b", outs, 7'b0);
      end
      ier_rda = 1'b0; ier_rls = 1'b0; rf_overrun = 1'b0;
      wb_rst_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (outs !== DR) begin
         miscompares++;
         $display("FAIL reset_release outs=%b expected=%b", outs, DR);
      end
   endtask

   task automatic test_pop_hold();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b0; ier_rls = 1'b0;
      t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, P|DR));
      for (int i = 0; i < 5; i++) t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, P|DR));
      t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL pop_hold[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_empty_read();
      stim_t t[$];
      logic [6:0] e;
      t.push_back(mk(1,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(1,0,0,8'h00,0,0,2,0,0, P|DR));
      t.push_back(mk(0,0,0,8'h00,0,0,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,2,0,0, DR));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL empty_read[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_clear_trig();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b1; ier_rls = 1'b0;
      t.push_back(mk(0,0,1,8'h40,0,0,3,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,3,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,4,0,0, DR|RD));
      t.push_back(mk(1,0,1,8'hC2,0,0,3,0,0, FR|DR));
      t.push_back(mk(1,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,0,0,8'h00,0,0,13,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,14,0,0, DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,13,0,0, DR));
      t.push_back(mk(1,0,0,8'h00,0,0,13,0,0, P|DR));
      t.push_back(mk(0,0,0,8'h00,0,0,13,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,13,0,0, DR));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL clear_trig[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_thresholds();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b1; ier_rls = 1'b0;
      t.push_back(mk(0,0,1,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,0,0,8'h00,0,0,1,0,0, DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,0,1,8'h80,0,0,7,0,0, DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,7,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,8,0,0, DR|RD));
      t.push_back(mk(0,0,1,8'h40,0,0,3,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,3,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,4,0,0, DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,3,0,0, DR));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL thresholds[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_timeout();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b1; ier_rls = 1'b0;
      t.push_back(mk(0,0,1,8'hC0,0,0,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,2,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,2,0,0, DR|TI));
      t.push_back(mk(0,0,0,8'h00,0,1,2,0,0, DR|TI));
      t.push_back(mk(0,0,0,8'h00,0,0,2,0,0, DR|TI));
      t.push_back(mk(1,0,0,8'h00,0,0,2,0,0, P|DR|TI));
      t.push_back(mk(1,0,0,8'h00,0,0,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,1,1,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,1,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,1,0,0,0, 7'b0));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL timeout[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_line_status();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b0; ier_rls = 1'b1;
      t.push_back(mk(0,0,0,8'h00,0,0,0,1,0, RL));
      t.push_back(mk(0,1,0,8'h00,0,0,0,1,0, RS));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,1, RL));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,1, RL));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,0, 7'b0));
      t.push_back(mk(0,1,0,8'h00,0,0,0,0,0, RS));
      t.push_back(mk(0,0,0,8'h00,0,0,0,0,0, 7'b0));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL line_status[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
      ier_rls = 1'b0;
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b0; ier_rls = 1'b0;
      t.push_back(mk(1,1,0,8'h00,0,0,5,0,0, P|RS|DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, P|DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,5,0,0, DR));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL back_to_back[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t t[$];
      logic [6:0] e;
      ier_rda = 1'b1; ier_rls = 1'b0;
      t.push_back(mk(0,0,1,8'h00,0,0,5,0,0, DR));
      t.push_back(mk(1,0,0,8'h00,0,0,5,0,0, P|DR|RD));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_pre[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
      wb_rst_i = 1'b1;
      #2;
      vectors++;
      if (outs !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_mid_async outs=%b expected=%b", outs, 7'b0);
      end
      @(posedge clk); #1;
      rbr_rd = 1'b0;
      wb_rst_i = 1'b0;
      t.delete();
      t.push_back(mk(0,0,0,8'h00,0,0,13,0,0, DR));
      t.push_back(mk(0,0,0,8'h00,0,0,14,0,0, DR|RD));
      t.push_back(mk(1,0,0,8'h00,0,0,14,0,0, P|DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,14,0,0, DR|RD));
      t.push_back(mk(0,0,0,8'h00,0,0,14,0,0, DR|RD));
      foreach (t[i]) begin
         drive(t[i]); sb.push_back(t[i].exp);
         @(posedge clk); #1;
         e = sb.pop_front(); vectors++;
         if (outs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_post[%0d] outs=%b expected=%b", i, outs, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog outs=%b expected=finish", outs);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_pop_hold();
      test_empty_read();
      test_clear_trig();
      test_thresholds();
      test_timeout();
      test_line_status();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
